// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests to instruction memory, in-order
// response buffering, and PC redirect on branch/jump with a drain of stale responses.
//   state    | meaning
//   ST_RUN   | fetching; responses are enqueued into the instruction buffer
//   ST_DRAIN | after a redirect; stale responses are dropped, no new requests raised
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    output logic [31:0] IMemAddr,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [5:0]  OPCode,
    output logic [5:0]  Function,
    output logic [4:0]  TargetReg,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus4,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              req_hold_q, req_hold_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic              fetch_en_q, fetch_en_d;
    logic [31:0]       buf_instr_q [BUF_DEPTH];
    logic [31:0]       buf_instr_d [BUF_DEPTH];
    logic [31:0]       buf_pc_q [BUF_DEPTH];
    logic [31:0]       buf_pc_d [BUF_DEPTH];

    logic              deq;
    logic              redirect;
    logic              req_fire;
    logic              rsp_take;
    logic              credit_ok;
    logic [CNT_W:0]    credit_use;
    logic [31:0]       branch_off;
    logic [31:0]       redirect_pc;
    logic              unused_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign InstrValid  = (cnt_q != '0);
    assign Instruction = InstrValid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign InstrPC     = InstrValid ? buf_pc_q[rd_ptr_q] : 32'h0;
    assign PCPlus4     = InstrPC + 32'd4;
    assign OPCode      = Instruction[31:26];
    assign Function    = Instruction[5:0];
    assign TargetReg   = Instruction[20:16];

    assign deq      = InstrValid && InstrReady;
    assign redirect = deq && (Branch || Jump || JumpReg);
    assign unused_ok = ^RegTarget[1:0];

    // Requests in flight plus buffered entries never exceed the buffer depth,
    // so every returning response is guaranteed a slot.
    assign credit_use = {1'b0, out_cnt_q} + {1'b0, cnt_q} - {{CNT_W{1'b0}}, deq};
    assign credit_ok  = (credit_use < DEPTH_C);

    assign IMemReqValid = req_hold_q || (fetch_en_q && (state_q == ST_RUN) && credit_ok);
    assign IMemAddr     = req_hold_q ? req_addr_q : fetch_pc_q;
    assign req_fire     = IMemReqValid && IMemReqReady;
    assign rsp_take     = IMemRspValid && (out_cnt_q != '0);

    assign branch_off = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

    always_comb begin
        redirect_pc = PCPlus4 + branch_off;
        if (JumpReg) begin
            redirect_pc = {RegTarget[31:2], 2'b00};
        end else if (Jump) begin
            redirect_pc = {PCPlus4[31:28], Instruction[25:0], 2'b00};
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        fetch_en_d  = 1'b1;
        req_hold_d  = IMemReqValid && !IMemReqReady;
        req_addr_d  = IMemReqValid ? IMemAddr : req_addr_q;
        out_cnt_d   = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_take);

        if (redirect) begin
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // A request still held at the redirect is stale too, so drain until it has
            // been accepted and its response dropped.
            state_d    = ((out_cnt_d != '0) || req_hold_d) ? ST_DRAIN : ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_take) begin
                buf_instr_d[wr_ptr_q] = IMemRspData;
                buf_pc_d[wr_ptr_q]    = rsp_pc_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
                rsp_pc_d              = rsp_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(rsp_take) - CNT_W'(deq);
        end else begin
            if ((out_cnt_d == '0) && !req_hold_d) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            req_hold_q <= 1'b0;
            req_addr_q <= RESET_PC;
            fetch_en_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= 32'h0;
                buf_pc_q[i]    <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            out_cnt_q   <= out_cnt_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            req_hold_q  <= req_hold_d;
            req_addr_q  <= req_addr_d;
            fetch_en_q  <= fetch_en_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of redirect vectors plus hand-written sequences
// for streaming, back-pressure, drain after redirect and asynchronous reset.
module tb_fetch_unit;
    logic        Clk;
    logic        Rst_n;
    logic        IMemReqValid;
    logic        IMemReqReady;
    logic [31:0] IMemAddr;
    logic        IMemRspValid;
    logic [31:0] IMemRspData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [5:0]  OPCode;
    logic [5:0]  Function;
    logic [4:0]  TargetReg;
    logic [31:0] InstrPC;
    logic [31:0] PCPlus4;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] RegTarget;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IMemReqValid(IMemReqValid), .IMemReqReady(IMemReqReady), .IMemAddr(IMemAddr),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instruction(Instruction),
        .OPCode(OPCode), .Function(Function), .TargetReg(TargetReg),
        .InstrPC(InstrPC), .PCPlus4(PCPlus4),
        .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .RegTarget(RegTarget)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          rsp_count = 0;
    int          last_rsp_cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] hs_log[$];
    int          hs_cyc_log[$];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_addr = 32'h0;
    logic [31:0] ovr_data = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && (a == ovr_addr)) return ovr_data;
        return {8'hC3, a[23:0]};
    endfunction

    // Memory model: accept at mid-cycle, answer in order mem_lat cycles later.
    always @(negedge Clk) begin
        if (Rst_n && IMemReqValid && IMemReqReady) begin
            q_addr.push_back(IMemAddr);
            q_due.push_back(cyc + mem_lat);
            hs_log.push_back(IMemAddr);
            hs_cyc_log.push_back(cyc);
        end
    end

    always @(posedge Clk) begin
        cyc = cyc + 1;
        #1;
        if (Rst_n && (q_addr.size() > 0) && (q_due[0] <= cyc)) begin
            IMemRspValid = 1'b1;
            IMemRspData  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
            rsp_count    = rsp_count + 1;
            last_rsp_cyc = cyc;
        end else begin
            IMemRspValid = 1'b0;
            IMemRspData  = 32'h0;
        end
    end

    always @(negedge Rst_n) begin
        q_addr.delete();
        q_due.delete();
        IMemRspValid = 1'b0;
        IMemRspData  = 32'h0;
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !InstrValid; i++) step();
        if (!InstrValid) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL %s: no InstrValid within 40 cycles", name);
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        InstrReady = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; RegTarget = 32'h0;
        IMemReqReady = 1'b1;
        repeat (2) step();
    endtask

    task automatic release_reset();
        IMemReqReady = 1'b1;
        hs_log.delete();
        hs_cyc_log.delete();
        rsp_count = 0;
        Rst_n = 1'b1;
    endtask

    task automatic consume(input logic br, input logic jmp, input logic jr, input logic [31:0] rt);
        InstrReady = 1'b1; Branch = br; Jump = jmp; JumpReg = jr; RegTarget = rt;
        step();
        InstrReady = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br;
        logic        jmp;
        logic        jr;
        logic [31:0] rtgt;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [31:0] pc4;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h1005_0003, 1'b1, 1'b0, 1'b0, 32'h0,         6'h04, 6'h03, 5'h05, 32'h0000_0014, 32'h0000_0020};
        vecs[1] = '{32'h0000_0010, 32'h111F_FFFF, 1'b1, 1'b0, 1'b0, 32'h0,         6'h04, 6'h3F, 5'h1F, 32'h0000_0014, 32'h0000_0010};
        vecs[2] = '{32'h3000_0040, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0,         6'h02, 6'h00, 5'h00, 32'h3000_0044, 32'h3000_0100};
        vecs[3] = '{32'h0000_0040, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'h0000_0203, 6'h00, 6'h08, 5'h00, 32'h0000_0044, 32'h0000_0200};
        vecs[4] = '{32'hFFFF_FFFC, 32'h1000_0001, 1'b1, 1'b0, 1'b0, 32'h0,         6'h04, 6'h01, 5'h00, 32'h0000_0000, 32'h0000_0004};
        vecs[5] = '{32'h0000_0100, 32'h1000_8000, 1'b1, 1'b0, 1'b0, 32'h0,         6'h04, 6'h00, 5'h00, 32'h0000_0104, 32'hFFFE_0104};
        vecs[6] = '{32'h0000_0050, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,         6'h37, 6'h2F, 5'h0D, 32'h0000_0054, 32'h0000_0054};
        vecs[7] = '{32'h0000_0060, 32'h0800_0010, 1'b1, 1'b1, 1'b0, 32'h0,         6'h02, 6'h10, 5'h00, 32'h0000_0064, 32'h0000_0040};

        IMemRspValid = 1'b0;
        IMemRspData  = 32'h0;

        // Values while reset is held
        do_reset();
        check("rst_req_valid", {31'h0, IMemReqValid}, 32'h0);
        check("rst_addr", IMemAddr, 32'h0);
        check("rst_instr_valid", {31'h0, InstrValid}, 32'h0);
        check("rst_instruction", Instruction, 32'h0);
        check("rst_instr_pc", InstrPC, 32'h0);
        check("rst_fields", {15'h0, OPCode, Function, TargetReg}, 32'h0);

        // Streaming with a 1-cycle memory and a decode stage that never stalls
        mem_lat = 1;
        release_reset();
        InstrReady = 1'b1;
        for (int i = 0; i < 20 && !InstrValid; i++) step();
        check("t1_first_valid_latency",
              (hs_cyc_log.size() > 0) ? 32'(cyc - hs_cyc_log[0]) : 32'hFFFF_FFFF, 32'd2);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t1_stream_pc%0d", k), InstrValid ? InstrPC : 32'hFFFF_FFFF, 32'(4 * k));
            check($sformatf("t1_stream_instr%0d", k), Instruction, {8'hC3, 24'(4 * k)});
            step();
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_req_addr%0d", k),
                  (hs_log.size() > k) ? hs_log[k] : 32'hFFFF_FFFF, 32'(4 * k));
        end
        InstrReady = 1'b0;

        // Back-pressure from decode right after reset
        do_reset();
        release_reset();
        repeat (12) step();
        check("t2_req_count", 32'(hs_log.size()), 32'd2);
        check("t2_req_valid_low", {31'h0, IMemReqValid}, 32'h0);
        check("t2_head_valid", {31'h0, InstrValid}, 32'h1);
        step();
        check("t2_head_pc_held", InstrPC, 32'h0);
        check("t2_head_instr_held", Instruction, 32'hC300_0000);
        check("t2_pc_plus4", PCPlus4, 32'h4);
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10 && hs_log.size() < 3; i++) step();
        check("t2_resume_addr", (hs_log.size() > 2) ? hs_log[2] : 32'hFFFF_FFFF, 32'h8);

        // Redirect vectors: jump to the vector PC, then consume it with the vector's controls
        for (int v = 0; v < 8; v++) begin
            do_reset();
            mem_lat  = 1;
            ovr_en   = 1'b1;
            ovr_addr = vecs[v].pc;
            ovr_data = vecs[v].instr;
            release_reset();
            wait_valid($sformatf("vec%0d_prelude", v));
            consume(1'b0, 1'b0, 1'b1, vecs[v].pc);
            wait_valid($sformatf("vec%0d_head", v));
            check($sformatf("vec%0d_pc", v), InstrPC, vecs[v].pc);
            check($sformatf("vec%0d_instr", v), Instruction, vecs[v].instr);
            check($sformatf("vec%0d_fields", v), {15'h0, OPCode, Function, TargetReg},
                  {15'h0, vecs[v].opc, vecs[v].fn, vecs[v].rt});
            check($sformatf("vec%0d_pc4", v), PCPlus4, vecs[v].pc4);
            consume(vecs[v].br, vecs[v].jmp, vecs[v].jr, vecs[v].rtgt);
            wait_valid($sformatf("vec%0d_next", v));
            check($sformatf("vec%0d_next_pc", v), InstrPC, vecs[v].next_pc);
        end
        ovr_en = 1'b0;

        // Redirect with two requests in flight on a 4-cycle memory
        begin
            int hs_at;
            int rsp_at;
            int bad;
            do_reset();
            mem_lat  = 4;
            ovr_en   = 1'b1;
            ovr_addr = 32'h4;
            ovr_data = 32'h1000_0010;
            release_reset();
            InstrReady = 1'b1;
            for (int i = 0; i < 40 && !(InstrValid && InstrPC == 32'h4); i++) step();
            Branch = 1'b1;
            step();
            Branch = 1'b0;
            hs_at  = hs_log.size();
            rsp_at = rsp_count;
            bad    = 0;
            check("t5_reqs_before_drain", 32'(hs_at), 32'd4);
            for (int i = 0; i < 30; i++) begin
                step();
                if (InstrValid) bad = bad + 1;
                if (hs_log.size() > hs_at) break;
            end
            check("t5_valid_during_drain", 32'(bad), 32'd0);
            check("t5_dropped_rsps", 32'(rsp_count - rsp_at), 32'd2);
            check("t5_new_req_addr", (hs_log.size() > hs_at) ? hs_log[hs_at] : 32'hFFFF_FFFF, 32'h48);
            check("t5_new_req_cycle",
                  (hs_cyc_log.size() > hs_at) ? 32'(hs_cyc_log[hs_at]) : 32'hFFFF_FFFF,
                  32'(last_rsp_cyc + 1));
            wait_valid("t5_after_drain");
            check("t5_target_pc", InstrPC, 32'h48);
            InstrReady = 1'b0;
            mem_lat    = 1;
            ovr_en     = 1'b0;
        end

        // Held request keeps its address across a redirect
        do_reset();
        release_reset();
        repeat (6) step();
        IMemReqReady = 1'b0;
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_held_valid", {31'h0, IMemReqValid}, 32'h1);
        check("t6_held_addr", IMemAddr, 32'h8);
        consume(1'b0, 1'b1, 1'b0, 32'h0);
        check("t6_held_addr_redirect", IMemAddr, 32'h8);
        check("t6_held_valid_redirect", {31'h0, IMemReqValid}, 32'h1);
        check("t6_flushed", {31'h0, InstrValid}, 32'h0);
        step();
        check("t6_held_addr_drain", IMemAddr, 32'h8);

        // Asynchronous reset mid-cycle with a stalled request and a valid head
        do_reset();
        release_reset();
        repeat (6) step();
        IMemReqReady = 1'b0;
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_pre_head_pc", InstrPC, 32'h4);
        #1;
        Rst_n = 1'b0;
        #1;
        check("t6_async_req_valid", {31'h0, IMemReqValid}, 32'h0);
        check("t6_async_addr", IMemAddr, 32'h0);
        check("t6_async_instr_valid", {31'h0, InstrValid}, 32'h0);
        check("t6_async_instruction", Instruction, 32'h0);
        check("t6_async_instr_pc", InstrPC, 32'h0);
        repeat (2) step();
        release_reset();
        for (int i = 0; i < 10 && hs_log.size() == 0; i++) step();
        check("t6_first_req_after_reset", (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch/issue front end feeding the combinational decode controller.
- Produces the instruction fields OPCode, Function and TargetReg, and consumes the controller's Branch, Jump and JumpReg outputs to redirect the PC.
- Talks to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers fetched instructions in a small FIFO so that decode-stage stalls and branch flushes are handled cleanly.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, instruction buffer entries; also caps requests in flight (minimum 2).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- IMemReqValid  out  1  fetch request valid.
- IMemReqReady  in  1  memory accepts the request this cycle.
- IMemAddr  out  32  fetch address; always word aligned.
- IMemRspValid  in  1  response valid. Responses return in order, exactly one per accepted request, with latency of 1 cycle or more.
- IMemRspData  in  32  instruction word.
- InstrValid  out  1  buffer head is valid.
- InstrReady  in  1  decode consumes the head this cycle.
- Instruction  out  32  head instruction word.
- OPCode  out  6  Instruction[31:26].
- Function  out  6  Instruction[5:0].
- TargetReg  out  5  Instruction[20:16].
- InstrPC  out  32  PC of the head instruction.
- PCPlus4  out  32  InstrPC + 4.
- Branch  in  1  controller: take branch for the head instruction.
- Jump  in  1  controller: J or JAL for the head instruction.
- JumpReg  in  1  controller: JR for the head instruction.
- RegTarget  in  32  rs value for JR.

Behaviour:
- Reset (async, Rst_n low): all outputs take these values while reset is held:
  - IMemReqValid=0, IMemAddr=RESET_PC.
  - InstrValid=0; Instruction, InstrPC and all field outputs = 0.
  - FetchPC=RESET_PC, buffer empty, outstanding count=0, state=RUN.
  - Reset asserted mid-transaction abandons all in-flight requests. Memory is reset with the core.
- Field outputs are pure slices of Instruction. PCPlus4 is InstrPC+4, wrapping modulo 2^32.
- Consume event: InstrValid && InstrReady. Branch, Jump and JumpReg are sampled only on a consume; they are ignored otherwise.
- Redirect target, by priority JumpReg > Jump > Branch:
  - JumpReg: {RegTarget[31:2],2'b00}.
  - Jump: {PCPlus4[31:28], Instruction[25:0], 2'b00}.
  - Branch: PCPlus4 + (sign-extended Instruction[15:0] << 2), modulo 2^32.
- There is no delay slot. On a redirect, every younger buffered instruction is discarded.
- Request issue (RUN only): IMemReqValid rises when outstanding + count − deq < BUF_DEPTH.
  - deq = consume this cycle.
  - Once asserted, IMemReqValid and IMemAddr hold until IMemReqReady. This holds even across a redirect.
  - On handshake: FetchPC += 4 and outstanding++.
- Response in RUN: {IMemRspData, address} is enqueued. The credit rule guarantees space.
  - Earliest InstrValid is one cycle after IMemRspValid; there is no bypass.
  - Simultaneous enqueue and dequeue is legal; count is unchanged.
- Redirect handling:
  - The buffer is flushed in the same edge and FetchPC is set to the target.
  - A response arriving in the redirect cycle is discarded.
  - A request handshaking in the redirect cycle counts as outstanding.
  - If outstanding after the edge is 0, the state stays RUN and the next request uses the target.
  - Otherwise the state moves to DRAIN.
- DRAIN state:
  - No new request is raised. A request already held valid is still completed.
  - All responses are discarded, decrementing outstanding.
  - InstrValid=0.
  - Moves to RUN on the edge where outstanding reaches 0.
- Full buffer: no new request; the head is held stable while InstrReady=0.
- Empty buffer: InstrValid=0; redirect inputs are ignored.
- IMemAddr never changes while IMemReqValid=1 && !IMemReqReady.

Test Plan:
1. 1-cycle memory, InstrReady=1 constantly -> addresses 0x0, 0x4, 0x8… in order. First InstrValid two cycles after the first handshake, then one instruction per cycle with no bubbles.
2. InstrReady=0 after reset -> exactly 2 requests issued; IMemReqValid then stays 0 and head (InstrPC=0x0) is held stable. Releasing InstrReady resumes fetch at 0x8.
3. Head InstrPC=0x10, Instruction[15:0]=0x0003, Branch=1 on consume -> buffered 0x14 is flushed; next InstrValid has InstrPC=0x20. A branch with imm 0xFFFF yields 0x10.
4. Head InstrPC=0x3000_0040, Jump=1, index 0x0000040 -> next InstrPC=0x3000_0100. With JumpReg=1 and Jump=1 simultaneously and RegTarget=0x0000_0203, the target is 0x0000_0200.
5. 4-cycle memory latency with 2 outstanding at redirect -> state enters DRAIN; both late responses are dropped, InstrValid stays 0, and the first new request goes to the target after the second response.
6. Rst_n pulsed low mid-stream with a request stalled (IMemReqReady=0) -> outputs immediately go to reset values without waiting for Clk. After release, the first request is to RESET_PC.
